// File: rtl/ec_fpn_mul_arb.sv
// ec_fpn_mul_arb
// ---------------------------------------------------------------------------
// Packet-level round-robin arbiter that lets NUM_IN point-arithmetic engines
// share one mod-P multiplier. Request packets (sop..eop) are forwarded whole,
// with the requester index written into the top two ctl bits. Result beats
// carry that index back, so the response path routes each beat to its owner
// and clears the tag. The request and response paths are independent.
//
// Ports (each AXI-stream style bundle is flattened; per-requester buses are
// packed with requester k at slice [k*W +: W]):
//   i_clk, i_rst          clock, synchronous active-high reset
//   req_*_i / req_rdy_o   NUM_IN request streams from the engines
//                         (dat = {b, a}, DAT_BITS wide; ctl CTL_BITS wide)
//   res_*_o / res_rdy_i   NUM_IN result streams back to the engines
//   mreq_*_o / mreq_rdy_i request stream into the multiplier
//   mres_*_i / mres_rdy_o result stream out of the multiplier
//   o_bad_tag             one-cycle pulse when a result carries tag >= NUM_IN
// ---------------------------------------------------------------------------
module ec_fpn_mul_arb #(
  parameter int NUM_IN     = 2,
  parameter int ARITH_BITS = 16,
  parameter int DAT_BITS   = 2*ARITH_BITS,
  parameter int RES_BITS   = ARITH_BITS,
  parameter int CTL_BITS   = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  // Requests from the engines
  input  logic [NUM_IN-1:0]            req_val_i,
  output logic [NUM_IN-1:0]            req_rdy_o,
  input  logic [NUM_IN*DAT_BITS-1:0]   req_dat_i,
  input  logic [NUM_IN*CTL_BITS-1:0]   req_ctl_i,
  input  logic [NUM_IN-1:0]            req_sop_i,
  input  logic [NUM_IN-1:0]            req_eop_i,
  input  logic [NUM_IN-1:0]            req_err_i,
  // Results back to the engines
  output logic [NUM_IN-1:0]            res_val_o,
  input  logic [NUM_IN-1:0]            res_rdy_i,
  output logic [NUM_IN*RES_BITS-1:0]   res_dat_o,
  output logic [NUM_IN*CTL_BITS-1:0]   res_ctl_o,
  output logic [NUM_IN-1:0]            res_sop_o,
  output logic [NUM_IN-1:0]            res_eop_o,
  output logic [NUM_IN-1:0]            res_err_o,
  // To the multiplier
  output logic                         mreq_val_o,
  input  logic                         mreq_rdy_i,
  output logic [DAT_BITS-1:0]          mreq_dat_o,
  output logic [CTL_BITS-1:0]          mreq_ctl_o,
  output logic                         mreq_sop_o,
  output logic                         mreq_eop_o,
  output logic                         mreq_err_o,
  // From the multiplier
  input  logic                         mres_val_i,
  output logic                         mres_rdy_o,
  input  logic [RES_BITS-1:0]          mres_dat_i,
  input  logic [CTL_BITS-1:0]          mres_ctl_i,
  input  logic                         mres_sop_i,
  input  logic                         mres_eop_i,
  input  logic                         mres_err_i,
  // Diagnostics
  output logic                         o_bad_tag
);

  localparam int GW = $clog2(NUM_IN);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  // -------------------------------------------------------------------------
  // Request path: arbitration state
  // -------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q,  last_d;

  logic            pick_found;
  logic [GW-1:0]   pick_idx;
  int              cand;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = 1; i <= NUM_IN; i++) begin
      cand = (int'(last_q) + i) % NUM_IN;
      if (!pick_found && req_val_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = GW'(cand);
      end
    end
  end

  // Beat presented by the current owner.
  logic [DAT_BITS-1:0] sel_dat;
  logic [CTL_BITS-1:0] sel_ctl;
  logic                sel_val, sel_sop, sel_eop, sel_err;

  always_comb begin
    sel_val = req_val_i[grant_q];
    sel_sop = req_sop_i[grant_q];
    sel_eop = req_eop_i[grant_q];
    sel_err = req_err_i[grant_q];
    sel_dat = req_dat_i[int'(grant_q)*DAT_BITS +: DAT_BITS];
    sel_ctl = req_ctl_i[int'(grant_q)*CTL_BITS +: CTL_BITS];
    // The tag field belongs to the arbiter; the engine's upper bits are replaced.
    sel_ctl[CTL_BITS-1 -: 2] = 2'(grant_q);
  end

  // The output register can take a beat when empty or draining this cycle.
  logic mreq_free;
  logic req_acc;

  assign mreq_free = ~mreq_val_o | mreq_rdy_i;
  assign req_acc   = (state_q == ST_LOCKED) & sel_val & mreq_free;

  always_comb begin
    req_rdy_o = '0;
    if (state_q == ST_LOCKED) begin
      req_rdy_o[grant_q] = mreq_free;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        // The lock holds across gaps in the owner's val until its eop beat.
        if (req_acc && sel_eop) begin
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_IN-1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // -------------------------------------------------------------------------
  // Request path: output register toward the multiplier
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mreq_val_o <= 1'b0;
      mreq_dat_o <= '0;
      mreq_ctl_o <= '0;
      mreq_sop_o <= 1'b0;
      mreq_eop_o <= 1'b0;
      mreq_err_o <= 1'b0;
    end else if (req_acc) begin
      mreq_val_o <= 1'b1;
      mreq_dat_o <= sel_dat;
      mreq_ctl_o <= sel_ctl;
      mreq_sop_o <= sel_sop;
      mreq_eop_o <= sel_eop;
      mreq_err_o <= sel_err;
    end else if (mreq_rdy_i) begin
      mreq_val_o <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Response path: route by tag, one output register per requester
  // -------------------------------------------------------------------------
  logic [1:0] res_tag;
  logic       res_bad;
  logic       mres_acc;

  assign res_tag  = mres_ctl_i[CTL_BITS-1 -: 2];
  assign res_bad  = (int'(res_tag) >= NUM_IN);

  // Unknown tags are swallowed so a corrupt beat cannot wedge the stream.
  always_comb begin
    mres_rdy_o = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(res_tag) == k) begin
        mres_rdy_o = ~res_val_o[k] | res_rdy_i[k];
      end
    end
  end

  assign mres_acc = mres_val_i & mres_rdy_o;

  logic [RES_BITS-1:0] res_dat_q [NUM_IN];
  logic [CTL_BITS-1:0] res_ctl_q [NUM_IN];
  logic [NUM_IN-1:0]   res_val_q, res_sop_q, res_eop_q, res_err_q;
  logic [CTL_BITS-1:0] res_ctl_clean;
  logic                bad_tag_q;

  always_comb begin
    res_ctl_clean = mres_ctl_i;
    res_ctl_clean[CTL_BITS-1 -: 2] = 2'b00;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      res_val_q <= '0;
      res_sop_q <= '0;
      res_eop_q <= '0;
      res_err_q <= '0;
      bad_tag_q <= 1'b0;
      for (int k = 0; k < NUM_IN; k++) begin
        res_dat_q[k] <= '0;
        res_ctl_q[k] <= '0;
      end
    end else begin
      bad_tag_q <= mres_acc & res_bad;
      for (int k = 0; k < NUM_IN; k++) begin
        if (mres_acc && (int'(res_tag) == k)) begin
          res_val_q[k] <= 1'b1;
          res_dat_q[k] <= mres_dat_i;
          res_ctl_q[k] <= res_ctl_clean;
          res_sop_q[k] <= mres_sop_i;
          res_eop_q[k] <= mres_eop_i;
          res_err_q[k] <= mres_err_i;
        end else if (res_rdy_i[k]) begin
          res_val_q[k] <= 1'b0;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_IN; k++) begin : g_res_out
    assign res_dat_o[k*RES_BITS +: RES_BITS] = res_dat_q[k];
    assign res_ctl_o[k*CTL_BITS +: CTL_BITS] = res_ctl_q[k];
  end

  assign res_val_o = res_val_q;
  assign res_sop_o = res_sop_q;
  assign res_eop_o = res_eop_q;
  assign res_err_o = res_err_q;
  assign o_bad_tag = bad_tag_q;

  // Engine-supplied bits in the tag field are overwritten and never read.
  logic unused_req_tag_bits;
  always_comb begin
    unused_req_tag_bits = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      unused_req_tag_bits = unused_req_tag_bits ^ (^req_ctl_i[k*CTL_BITS + CTL_BITS-2 +: 2]);
    end
  end

endmodule

// File: tb/tb_ec_fpn_mul_arb.sv
module tb_ec_fpn_mul_arb;

  localparam int NUM_IN = 2;
  localparam int AB     = 8;
  localparam int DB     = 2*AB;
  localparam int RB     = AB;
  localparam int CB     = 8;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  logic [NUM_IN-1:0]    req_val_i = '0, req_rdy_o;
  logic [NUM_IN*DB-1:0] req_dat_i = '0;
  logic [NUM_IN*CB-1:0] req_ctl_i = '0;
  logic [NUM_IN-1:0]    req_sop_i = '0, req_eop_i = '0, req_err_i = '0;
  logic [NUM_IN-1:0]    res_val_o, res_rdy_i = '0;
  logic [NUM_IN*RB-1:0] res_dat_o;
  logic [NUM_IN*CB-1:0] res_ctl_o;
  logic [NUM_IN-1:0]    res_sop_o, res_eop_o, res_err_o;
  logic                 mreq_val_o, mreq_rdy_i = 1'b0;
  logic [DB-1:0]        mreq_dat_o;
  logic [CB-1:0]        mreq_ctl_o;
  logic                 mreq_sop_o, mreq_eop_o, mreq_err_o;
  logic                 mres_val_i = 1'b0, mres_rdy_o;
  logic [RB-1:0]        mres_dat_i = '0;
  logic [CB-1:0]        mres_ctl_i = '0;
  logic                 mres_sop_i = 1'b0, mres_eop_i = 1'b0, mres_err_i = 1'b0;
  logic                 o_bad_tag;

  ec_fpn_mul_arb #(
    .NUM_IN(NUM_IN), .ARITH_BITS(AB), .DAT_BITS(DB), .RES_BITS(RB), .CTL_BITS(CB)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .req_val_i(req_val_i), .req_rdy_o(req_rdy_o), .req_dat_i(req_dat_i),
    .req_ctl_i(req_ctl_i), .req_sop_i(req_sop_i), .req_eop_i(req_eop_i),
    .req_err_i(req_err_i),
    .res_val_o(res_val_o), .res_rdy_i(res_rdy_i), .res_dat_o(res_dat_o),
    .res_ctl_o(res_ctl_o), .res_sop_o(res_sop_o), .res_eop_o(res_eop_o),
    .res_err_o(res_err_o),
    .mreq_val_o(mreq_val_o), .mreq_rdy_i(mreq_rdy_i), .mreq_dat_o(mreq_dat_o),
    .mreq_ctl_o(mreq_ctl_o), .mreq_sop_o(mreq_sop_o), .mreq_eop_o(mreq_eop_o),
    .mreq_err_o(mreq_err_o),
    .mres_val_i(mres_val_i), .mres_rdy_o(mres_rdy_o), .mres_dat_i(mres_dat_i),
    .mres_ctl_i(mres_ctl_i), .mres_sop_i(mres_sop_i), .mres_eop_i(mres_eop_i),
    .mres_err_i(mres_err_i),
    .o_bad_tag(o_bad_tag)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int            owner;     // -1 when no packet owns the multiplier port
  int            last;
  bit            mo_val;
  logic [DB-1:0] mo_dat;
  logic [CB-1:0] mo_ctl;
  logic [2:0]    mo_flags;  // {sop, eop, err}
  bit            rs_val [NUM_IN];
  logic [RB-1:0] rs_dat [NUM_IN];
  logic [CB-1:0] rs_ctl [NUM_IN];
  logic [2:0]    rs_flags [NUM_IN];
  bit            exp_bad;

  task automatic model_reset();
    owner = -1;
    last  = NUM_IN-1;
    mo_val = 0; mo_dat = '0; mo_ctl = '0; mo_flags = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      rs_val[k] = 0; rs_dat[k] = '0; rs_ctl[k] = '0; rs_flags[k] = '0;
    end
    exp_bad = 0;
  endtask

  // ---------------- stimulus generators ----------------
  typedef struct {
    int cyc; int pv0; int pv1; int len; int ctl05;
    int pmr; int pres; int prr; int pbad; int rst_at;
  } phase_t;
  phase_t ph [5];

  bit            pres   [NUM_IN];
  bit            in_pkt [NUM_IN];
  int            bidx   [NUM_IN];
  int            plen   [NUM_IN];
  logic [CB-1:0] pctl   [NUM_IN];
  bit            racc   [NUM_IN];
  bit            mr_pres, mr_acc;
  bit            just_reset;

  initial begin
    int            pv [NUM_IN];
    bit            slot_free, acc, bad;
    int            t;
    logic [CB-1:0] c;

    ph[0] = '{60,  100, 0,   4, 1, 100, 50, 100, 0,  -1};
    ph[1] = '{100, 100, 100, 4, 0, 100, 60, 100, 0,  -1};
    ph[2] = '{400, 60,  60,  0, 0, 70,  70, 60,  10, -1};
    ph[3] = '{300, 80,  80,  0, 0, 80,  80, 80,  15, 150};
    ph[4] = '{200, 30,  30,  0, 0, 30,  30, 30,  20, 77};

    for (int k = 0; k < NUM_IN; k++) begin
      pres[k] = 0; in_pkt[k] = 0; bidx[k] = 0; plen[k] = 1; pctl[k] = '0; racc[k] = 0;
    end
    mr_pres = 0; mr_acc = 0; just_reset = 0;
    model_reset();

    for (int p = 0; p < 5; p++) begin
      pv[0] = ph[p].pv0;
      pv[1] = ph[p].pv1;
      for (int cy = 0; cy < ph[p].cyc; cy++) begin
        @(posedge i_clk);
        #1;
        i_rst = ((p == 0 && cy < 2) || cy == ph[p].rst_at) ? 1'b1 : 1'b0;
        if (i_rst) begin
          for (int k = 0; k < NUM_IN; k++) begin
            pres[k] = 0; in_pkt[k] = 0; racc[k] = 0;
          end
          mr_pres = 0; mr_acc = 0;
        end
        // requesters: hold a beat until taken, start packets at sop
        for (int k = 0; k < NUM_IN; k++) begin
          if (racc[k]) begin
            pres[k] = 0;
            if (bidx[k] == plen[k]-1) in_pkt[k] = 0;
            else bidx[k]++;
          end
          if (!i_rst && !pres[k] && ($urandom_range(0, 99) < pv[k])) begin
            if (!in_pkt[k]) begin
              in_pkt[k] = 1;
              bidx[k]   = 0;
              plen[k]   = (ph[p].len != 0) ? ph[p].len : int'($urandom_range(1, 4));
              pctl[k]   = ph[p].ctl05 ? 8'h05 : 8'($urandom);
            end
            pres[k] = 1;
            req_dat_i[k*DB +: DB] = DB'($urandom);
            req_ctl_i[k*CB +: CB] = pctl[k];
            req_sop_i[k] = (bidx[k] == 0);
            req_eop_i[k] = (bidx[k] == plen[k]-1);
            req_err_i[k] = ($urandom_range(0, 9) == 0);
          end
          req_val_i[k] = pres[k];
          res_rdy_i[k] = ($urandom_range(0, 99) < ph[p].prr);
        end
        mreq_rdy_i = ($urandom_range(0, 99) < ph[p].pmr);
        // multiplier result source
        if (mr_acc) mr_pres = 0;
        if (!i_rst && !mr_pres && ($urandom_range(0, 99) < ph[p].pres)) begin
          mr_pres = 1;
          c = 8'($urandom);
          if ($urandom_range(0, 99) < ph[p].pbad) c[7:6] = 2'($urandom_range(2, 3));
          else c[7:6] = 2'($urandom_range(0, NUM_IN-1));
          mres_ctl_i = c;
          mres_dat_i = RB'($urandom);
          mres_sop_i = 1'($urandom);
          mres_eop_i = 1'($urandom);
          mres_err_i = 1'($urandom);
        end
        mres_val_i = mr_pres;

        @(negedge i_clk);
        if (i_rst) begin
          model_reset();
          just_reset = 1;
          continue;
        end

        // ---- request side ----
        slot_free = !mo_val || mreq_rdy_i;
        for (int k = 0; k < NUM_IN; k++)
          chk($sformatf("req_rdy[%0d]", k), 64'(req_rdy_o[k]), 64'((owner == k) && slot_free));
        chk("mreq_val", 64'(mreq_val_o), 64'(mo_val));
        if (mo_val || just_reset) begin
          chk("mreq_dat", 64'(mreq_dat_o), 64'(mo_dat));
          chk("mreq_ctl", 64'(mreq_ctl_o), 64'(mo_ctl));
          chk("mreq_flags", 64'({mreq_sop_o, mreq_eop_o, mreq_err_o}), 64'(mo_flags));
        end
        acc = (owner >= 0) && req_val_i[owner] && slot_free;
        if (acc) begin
          mo_val   = 1;
          mo_dat   = req_dat_i[owner*DB +: DB];
          mo_ctl   = {2'(owner), req_ctl_i[owner*CB +: CB-2]};
          mo_flags = {req_sop_i[owner], req_eop_i[owner], req_err_i[owner]};
        end else if (mreq_rdy_i) begin
          mo_val = 0;
        end
        if (owner < 0) begin
          for (int i = 1; i <= NUM_IN; i++) begin
            if (owner < 0 && req_val_i[(last + i) % NUM_IN]) owner = (last + i) % NUM_IN;
          end
        end else if (acc && req_eop_i[owner]) begin
          last  = owner;
          owner = -1;
        end
        for (int k = 0; k < NUM_IN; k++) racc[k] = req_val_i[k] && req_rdy_o[k];

        // ---- response side ----
        t   = int'(mres_ctl_i[CB-1 -: 2]);
        bad = (t >= NUM_IN);
        chk("mres_rdy", 64'(mres_rdy_o), 64'(bad || !rs_val[t] || res_rdy_i[t]));
        for (int k = 0; k < NUM_IN; k++) begin
          chk($sformatf("res_val[%0d]", k), 64'(res_val_o[k]), 64'(rs_val[k]));
          if (rs_val[k] || just_reset) begin
            chk($sformatf("res_dat[%0d]", k), 64'(res_dat_o[k*RB +: RB]), 64'(rs_dat[k]));
            chk($sformatf("res_ctl[%0d]", k), 64'(res_ctl_o[k*CB +: CB]), 64'(rs_ctl[k]));
            chk($sformatf("res_flags[%0d]", k),
                64'({res_sop_o[k], res_eop_o[k], res_err_o[k]}), 64'(rs_flags[k]));
          end
        end
        chk("bad_tag", 64'(o_bad_tag), 64'(exp_bad));
        acc = mres_val_i && (bad || !rs_val[t] || res_rdy_i[t]);
        exp_bad = acc && bad;
        for (int k = 0; k < NUM_IN; k++) begin
          if (acc && !bad && t == k) begin
            rs_val[k]   = 1;
            rs_dat[k]   = mres_dat_i;
            rs_ctl[k]   = {2'b00, mres_ctl_i[CB-3:0]};
            rs_flags[k] = {mres_sop_i, mres_eop_i, mres_err_i};
          end else if (res_rdy_i[k]) begin
            rs_val[k] = 0;
          end
        end
        mr_acc = mres_val_i && mres_rdy_o;
        just_reset = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
